// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell walks a WIDTH-bit operand
// pair LSB first, one bit per clock, behind a start/busy/done handshake.
// Results (sum, cout, ovf) are registered and change only on completion.

// Single-bit full adder cell reused for every bit position.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, nstate;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_co;
  logic             accept, last;

  // start is honoured in IDLE and in the single DONE cycle, never in RUN
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  full_adder u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // Next-state logic; DONE always leaves after one cycle
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (last)  nstate = DONE;
      DONE:    nstate = start ? RUN : IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, per-bit shifting and result commit on the last bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
      carry  <= fa_co;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        // carry still holds the carry into the MSB at this point
        sum  <= {fa_s, sum_sh[WIDTH-1:1]};
        cout <= fa_co;
        ovf  <= carry ^ fa_co;
      end
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that sequences a single FullAdder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. Operands are captured on a start/busy/done handshake; the block holds the carry between bits, shifts the sum in, and presents the registered result plus carry-out and signed overflow. It trades area for latency: one FullAdder instance instead of a WIDTH-bit ripple chain, sitting beside the lab ALU datapath.

Parameters:
WIDTH, 8, operand/sum width in bits (legal range 2..32).
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE or DONE
a  in  WIDTH  operand A, captured on accepted start
b  in  WIDTH  operand B, captured on accepted start
cin  in  1  carry-in, captured on accepted start
busy  out  1  high while bits are being processed (RUN)
done  out  1  one-cycle pulse when the result becomes valid
sum  out  WIDTH  registered sum, held until the next accepted start completes
cout  out  1  registered final carry-out
ovf  out  1  registered signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers, carry and counter cleared. Reset mid-RUN abandons the operation; no done pulse.
- States: IDLE, RUN, DONE. State, counter and all outputs are registered; no combinational path from inputs to outputs.
- IDLE: start=1 at edge k → capture a, b into shift registers, carry reg ← cin, counter ← 0, state ← RUN. busy=1 from after edge k.
- RUN: each edge, FullAdder inputs are a_sh[0], b_sh[0], carry reg.
  - s is shifted into sum_sh from the MSB side; a_sh and b_sh shift right by one; carry reg ← co; counter += 1.
  - On the edge where counter = WIDTH-1 (the WIDTH-th bit, edge k+WIDTH):
    - sum ← final sum_sh value including this bit.
    - cout ← co.
    - ovf ← (carry reg at this bit) XOR co.
    - state ← DONE, busy ← 0, done ← 1.
- Latency: start accepted at edge k → done high for exactly the cycle after edge k+WIDTH. sum, cout and ovf are valid in that same cycle.
- DONE: lasts exactly one cycle. Next edge → IDLE and done ← 0. If start=1 on that edge, a new operation is accepted (behaves as IDLE acceptance) and the state goes to RUN, giving back-to-back operations with a one-cycle gap.
- start while RUN: ignored. Operand and cin changes during RUN have no effect.
- sum, cout and ovf are updated only at completion. A new operation leaves the old result visible until its own completion.
- Arithmetic: unsigned modulo 2^WIDTH with carry-out; ovf interprets operands as two's complement.

Test Plan:
- Reset then idle, WIDTH=8: hold reset 3 cycles, start=0 for 20 cycles → busy=0, done=0, sum=0x00, cout=0, ovf=0 throughout.
- Basic add: start with a=0x35, b=0x1A, cin=0 → busy high 8 cycles; done pulses one cycle after edge k+8 with sum=0x4F, cout=0, ovf=0.
- Carry/wrap: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1, ovf=0.
- Signed overflow: a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1.
- Handshake edges: pulse start again mid-RUN with different operands → ignored, original result delivered. Hold start=1 continuously → new operations accepted on each DONE cycle, done every 9 cycles, sum held between completions.
- Reset mid-operation: assert reset asynchronously at bit 4 of a=0x35, b=0x1A → outputs go to 0 immediately with no done pulse; a subsequent start yields the correct fresh result.
- Random regression, WIDTH=8 and WIDTH=16: ≥1000 random a, b, cin → {cout,sum} == a+b+cin and ovf matches the two's-complement reference model.
